// File: rtl/morty_ifetch_unit.sv
// morty_ifetch_unit: Wishbone classic instruction-fetch master feeding the IF stage.
module morty_ifetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic [31:0] instruction_o,
  output logic        inst_valid_o,
  output logic        inst_access_fault_o,
  output logic        fetch_stall_o,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, buf_q, buf_d, data;
  logic [15:0] cnt_q, cnt_d;
  logic        flt_q, flt_d, valid, fault, tmo, flt, resp;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
    end
  end
  // a timeout only counts when the slave stays silent in that cycle
  always_comb begin
    tmo     = (cnt_q == TO_LAST) && !iwbm_ack_i && !iwbm_err_i;
    flt     = iwbm_err_i | tmo;
    resp    = iwbm_ack_i | iwbm_err_i | tmo;
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    flt_d   = flt_q;
    cnt_d   = cnt_q;
    valid   = 1'b0;
    fault   = 1'b0;
    data    = NOP_INST;
    case (state_q)
      IDLE: begin
        if (!flush_i && !hold_i) begin
          if (pc_i[1:0] != 2'b00) valid = 1'b1;
          else begin
            addr_d  = pc_i;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
        if (flush_i) state_d = IDLE;
        else if (resp && hold_i) begin
          buf_d   = flt ? NOP_INST : iwbm_dat_i;
          flt_d   = flt;
          state_d = HOLD;
        end else if (resp) begin
          valid   = 1'b1;
          fault   = flt;
          data    = flt ? NOP_INST : iwbm_dat_i;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (flush_i) begin
          buf_d   = '0;
          flt_d   = 1'b0;
          state_d = IDLE;
        end else if (!hold_i) begin
          valid   = 1'b1;
          fault   = flt_q;
          data    = buf_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign inst_valid_o        = valid & rst_i;
  assign instruction_o       = inst_valid_o ? data : NOP_INST;
  assign inst_access_fault_o = inst_valid_o & fault;
  assign fetch_stall_o       = ~inst_valid_o;
  assign iwbm_addr_o         = addr_q;
  assign iwbm_cyc_o          = (state_q == REQ);
  assign iwbm_stb_o          = (state_q == REQ);
endmodule

// File: doc/morty_ifetch_unit.md
Name: morty_ifetch_unit

Overview:
- Instruction-fetch bus master that sits directly upstream of the IF stage.
- Takes the current PC from the IF stage and runs a Wishbone classic read on the instruction bus.
- Returns the instruction word and an access-fault flag.
- Drives the IF stall while a fetch is outstanding; an IF-side flush (branch, jump or exception redirect) aborts an in-flight fetch.

Parameters:
TIMEOUT_CYCLES, 255, number of REQ cycles without ack/err before the fetch is terminated as an access fault (legal range 1..65535)
NOP_INST, 32'h0000_0013, word returned on fault or misaligned PC

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
pc_i  in  32  fetch address from IF stage PC register
flush_i  in  1  kill current or pending fetch (IF redirect)
hold_i  in  1  downstream (ID) stall; no handoff while high
instruction_o  out  32  fetched word, valid when inst_valid_o=1
inst_valid_o  out  1  one-cycle handoff strobe
inst_access_fault_o  out  1  qualifies instruction_o as a faulted fetch
fetch_stall_o  out  1  stall to IF stage; equals ~inst_valid_o
iwbm_addr_o  out  32  Wishbone address
iwbm_cyc_o  out  1  Wishbone cycle
iwbm_stb_o  out  1  Wishbone strobe
iwbm_dat_i  in  32  Wishbone read data
iwbm_ack_i  in  1  Wishbone ack
iwbm_err_i  in  1  Wishbone error

Behaviour:
Reset (rst_i=0, asynchronous)
- state=IDLE; iwbm_cyc_o=iwbm_stb_o=0; iwbm_addr_o=0; timeout counter=0; hold buffer=0.
- Outputs during reset: inst_valid_o=0, fetch_stall_o=1, inst_access_fault_o=0, instruction_o=NOP_INST.
- Reset mid-REQ drops cyc/stb immediately; no valid strobe follows.

States: IDLE, REQ, HOLD. flush_i has priority over all other inputs in every state.

IDLE
- flush_i=1 or hold_i=1: stay in IDLE, nothing issued.
- pc_i[1:0]!=0: no bus cycle. Combinational inst_valid_o=1 this cycle, instruction_o=NOP_INST, fault=0. The IF stage raises its own misaligned trap. Stay in IDLE.
- Otherwise: register iwbm_addr_o=pc_i, set cyc/stb=1, clear counter, go to REQ.

REQ
- cyc/stb held high; counter increments each cycle.
- flush_i=1: cyc/stb=0 at the next edge, go to IDLE. Any ack/err in that cycle or later is ignored.
- ack_i or err_i, hold_i=0: combinational inst_valid_o=1 in the same cycle.
  - instruction_o = dat_i on ack, NOP_INST on err.
  - fault = err_i; err wins if both are asserted.
  - Next edge: cyc/stb=0, go to IDLE.
- ack_i or err_i, hold_i=1: latch data/fault into the hold buffer, drop cyc/stb, go to HOLD. inst_valid_o=0.
- Timeout: counter reaches TIMEOUT_CYCLES-1 with no ack/err. Treated exactly as err_i, with the same hold_i rules.
  - TIMEOUT_CYCLES=1 faults on the first REQ cycle with no response.

HOLD
- flush_i=1: discard buffer, go to IDLE, no strobe.
- hold_i=0: inst_valid_o=1 from buffer this cycle, go to IDLE.
- Otherwise stay in HOLD.

General rules
- Outputs when inst_valid_o=0: instruction_o=NOP_INST, inst_access_fault_o=0.
- fetch_stall_o = ~inst_valid_o in all states.
- Exactly one inst_valid_o pulse per issued, unflushed fetch.
- Throughput: minimum 2 cycles per instruction (IDLE then REQ with zero-wait ack).
- iwbm_addr_o is stable for the whole REQ; pc_i changes during REQ are ignored.
- Counter width is 16 bits and saturates; it never wraps.

Test Plan:
1. Release reset, pc_i=0, ack at 2nd REQ cycle with dat=0x00500093 -> cyc/stb rise 1 cycle after IDLE; addr=0; inst_valid_o one-cycle pulse on the ack cycle; instruction_o=0x00500093; fault=0; fetch_stall_o low only that cycle.
2. pc_i=0x100, err_i=1 on 1st REQ cycle -> inst_valid_o=1, fault=1, instruction_o=0x00000013, cyc low next edge.
3. TIMEOUT_CYCLES=4, no ack -> 4 REQ cycles; fault strobe on the 4th; cyc low after; a later stray ack is ignored.
4. ack with dat=0xDEADBEEF while hold_i=1, hold_i held 3 more cycles -> no strobe while held; single strobe with 0xDEADBEEF the cycle hold_i falls.
5. flush_i pulse on 2nd REQ cycle, ack one cycle later -> cyc/stb low after flush edge; no inst_valid_o; the next IDLE issues the new pc_i=0x200.
6. pc_i=0x002 in IDLE -> no cyc; inst_valid_o=1 same cycle with 0x00000013, fault=0. Then rst_i=0 mid-REQ on an aligned fetch -> cyc/stb drop asynchronously; no strobe.
